match_controller: RTL and testbench

Sequencing and arbitration controller for the two-player score counter. Accepts hit requests from two player inputs over a request/acknowledge handshake, grants one at a time with round-robin priority, and converts each grant into a single-cycle score pulse for the counter's WINNER/LOSER inputs. Enforces a post-point lockout, clears the counter at match start, and latches the counter's game-over result until the next match.

---
 rtl/match_controller.sv | 148 ++++++++++++++
 tb/tb_match_controller.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Round-robin hit arbiter and match sequencer for the two-player score counter.
// Optional match-abort timeout is compiled in with `define MATCH_TIMEOUT_EN.
module match_controller #(
  parameter int LOCKOUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit1,
  input  logic       hit2,
  output logic       ack1,
  output logic       ack2,
  output logic       score_w,
  output logic       score_l,
  output logic       cnt_rst,
  input  logic       gameover,
  input  logic [1:0] who,
  output logic [1:0] result,
  output logic       done,
  output logic       busy,
  output logic       timeout
);
  localparam int LW = $clog2(LOCKOUT + 1);

  // gameover arrives in LOCK cycle 1, so a 1-cycle lock would miss it
  if (LOCKOUT < 2 || LOCKOUT > 255) begin : g_bad_lockout
    $error("LOCKOUT must be within 2..255");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, PLAY, LOCK, OVER} state_t;

  state_t        state;
  logic [LW-1:0] lock_cnt;
  logic          ptr;      // 0: player 1 wins a tie, 1: player 2 wins a tie
  logic          g1, g2;

`ifdef MATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    g1 = hit1 & (~hit2 | ~ptr);
    g2 = hit2 & ~g1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt_rst  <= 1'b1;
      ack1     <= 1'b0;
      ack2     <= 1'b0;
      score_w  <= 1'b0;
      score_l  <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      result   <= 2'b00;
      ptr      <= 1'b0;
      lock_cnt <= '0;
`ifdef MATCH_TIMEOUT_EN
      timeout  <= 1'b0;
      to_cnt   <= '0;
`endif
    end else begin
      ack1    <= 1'b0;
      ack2    <= 1'b0;
      score_w <= 1'b0;
      score_l <= 1'b0;
      case (state)
        IDLE: begin
          cnt_rst <= 1'b1;
          if (start) begin
            state  <= CLEAR;
            result <= 2'b00;
            ptr    <= 1'b0;
`ifdef MATCH_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        CLEAR: begin
          state   <= PLAY;
          cnt_rst <= 1'b0;
          busy    <= 1'b1;
`ifdef MATCH_TIMEOUT_EN
          to_cnt  <= '0;
`endif
        end
        PLAY: begin
          if (g1 | g2) begin
            state    <= LOCK;
            ack1     <= g1;
            score_w  <= g1;
            ack2     <= g2;
            score_l  <= g2;
            ptr      <= g1;   // next tie goes to whoever was not just served
            lock_cnt <= LW'(LOCKOUT - 1);
          end
`ifdef MATCH_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT - 1)) begin
            state   <= OVER;
            busy    <= 1'b0;
            done    <= 1'b1;
            result  <= 2'b00;
            timeout <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
`endif
        end
        LOCK: begin
          if (gameover) begin
            state  <= OVER;
            result <= who;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (lock_cnt == '0) begin
            state <= PLAY;
`ifdef MATCH_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end else begin
            lock_cnt <= lock_cnt - LW'(1);
          end
        end
        OVER: begin
          if (start) begin
            state   <= CLEAR;
            cnt_rst <= 1'b1;
            done    <= 1'b0;
            result  <= 2'b00;
            ptr     <= 1'b0;
`ifdef MATCH_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_match_controller.sv
// Randomized self-checking bench for match_controller with a score-counter model.
module tb_match_controller;
  localparam int LOCKOUT = 4;
  localparam int TIMEOUT = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       hit1 = 1'b0;
  logic       hit2 = 1'b0;
  logic       gameover = 1'b0;
  logic [1:0] who = 2'b00;
  logic       ack1, ack2, score_w, score_l, cnt_rst, done, busy, timeout;
  logic [1:0] result;

  int total = 0;
  int bad = 0;

  match_controller #(.LOCKOUT(LOCKOUT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .hit1(hit1), .hit2(hit2),
    .ack1(ack1), .ack2(ack2), .score_w(score_w), .score_l(score_l),
    .cnt_rst(cnt_rst), .gameover(gameover), .who(who), .result(result),
    .done(done), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Score counter model: counts pulses, raises a one-cycle gameover the cycle after the winning pulse
  int   target = 255;
  int   sc1 = 0, sc2 = 0;
  bit   go_pend = 0;
  logic [1:0] who_pend = 2'b00;
  always @(posedge clk) begin
    #1;
    gameover = go_pend;
    who      = go_pend ? who_pend : 2'b00;
    go_pend  = 0;
    if (cnt_rst) begin
      sc1 = 0;
      sc2 = 0;
    end else begin
      if (score_w) begin
        sc1++;
        if (sc1 == target) begin go_pend = 1; who_pend = 2'b10; end
      end
      if (score_l) begin
        sc2++;
        if (sc2 == target) begin go_pend = 1; who_pend = 2'b01; end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start = 0; hit1 = 0; hit2 = 0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 0;
  endtask

  // returns at the negedge of the first PLAY cycle
  task automatic start_match();
    start = 1;
    @(posedge clk); @(negedge clk);
    start = 0;
    total++;
    if (cnt_rst !== 1'b1 || result !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL clear_cycle got cnt_rst=%b result=%b busy=%b done=%b want 1 00 0 0",
               cnt_rst, result, busy, done);
    end
    @(negedge clk);
    total++;
    if (cnt_rst !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL play_entry got cnt_rst=%b busy=%b want 0 1", cnt_rst, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    total++;
    if ({cnt_rst, ack1, ack2, score_w, score_l, done, busy, timeout, result} !== 10'b10000000_00) begin
      bad++;
      $display("FAIL reset_outputs got %b want 1000000000",
               {cnt_rst, ack1, ack2, score_w, score_l, done, busy, timeout, result});
    end
    rst = 0;
    hit1 = 1; hit2 = 1;
    repeat (6) begin
      @(negedge clk);
      total++;
      if (ack1 !== 1'b0 || ack2 !== 1'b0 || busy !== 1'b0 || cnt_rst !== 1'b1) begin
        bad++;
        $display("FAIL idle_ignores_hits got ack1=%b ack2=%b busy=%b cnt_rst=%b want 0 0 0 1",
                 ack1, ack2, busy, cnt_rst);
      end
    end
    hit1 = 0; hit2 = 0;
  endtask

  task automatic test_single_point();
    int k;
    do_reset();
    start_match();
    hit1 = 1;
    @(posedge clk); @(negedge clk);
    total++;
    if ({ack1, score_w, ack2, score_l} !== 4'b1100) begin
      bad++;
      $display("FAIL single_grant got ack1/score_w/ack2/score_l=%b want 1100",
               {ack1, score_w, ack2, score_l});
    end
    hit1 = 0;
    @(negedge clk);
    total++;
    if (ack1 !== 1'b0 || score_w !== 1'b0) begin
      bad++;
      $display("FAIL single_pulse_width got ack1=%b score_w=%b want 0 0", ack1, score_w);
    end
    hit1 = 1;   // new request during lock stays pending
    k = 1;
    while (ack1 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    hit1 = 0;
    total++;
    if (k != LOCKOUT + 1) begin
      bad++;
      $display("FAIL grant_spacing got %0d cycles want %0d", k, LOCKOUT + 1);
    end
  endtask

  task automatic test_simultaneous();
    int seq_p[$];
    int seq_c[$];
    do_reset();
    start_match();
    hit1 = 1; hit2 = 1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (ack1 && ack2) begin
        total++; bad++;
        $display("FAIL simul_double_ack at cycle %0d got both want one", c);
      end
      if (ack1) begin seq_p.push_back(1); seq_c.push_back(c); end
      else if (ack2) begin seq_p.push_back(2); seq_c.push_back(c); end
    end
    hit1 = 0; hit2 = 0;
    total++;
    if (seq_p.size() != 7) begin
      bad++;
      $display("FAIL simul_grant_count got %0d want 7", seq_p.size());
    end
    for (int i = 0; i < seq_p.size(); i++) begin
      total++;
      if (seq_p[i] != (i % 2 == 0 ? 1 : 2) || seq_c[i] != 1 + i * (LOCKOUT + 1)) begin
        bad++;
        $display("FAIL simul_grant_%0d got player=%0d cycle=%0d want player=%0d cycle=%0d",
                 i, seq_p[i], seq_c[i], (i % 2 == 0 ? 1 : 2), 1 + i * (LOCKOUT + 1));
      end
    end
  endtask

  task automatic test_full_match();
    int grants = 0;
    int budget;
    do_reset();
    target = 15;
    start_match();
    while (grants < 15) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      hit1 = 1;
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (ack1 !== 1'b1 && budget < 30);
      hit1 = 0;
      if (ack1 !== 1'b1) begin
        total++; bad++;
        $display("FAIL full_match_wait got no ack after %0d cycles want ack", budget);
        break;
      end
      grants++;
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL lock_cycle1 got busy=%b done=%b want 1 0", busy, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || result !== 2'b10 || busy !== 1'b0 || timeout !== 1'b0) begin
      bad++;
      $display("FAIL match_over got done=%b result=%b busy=%b timeout=%b want 1 10 0 0",
               done, result, busy, timeout);
    end
    hit1 = 1;
    repeat (4) begin
      @(negedge clk);
      total++;
      if (ack1 !== 1'b0 || done !== 1'b1 || result !== 2'b10) begin
        bad++;
        $display("FAIL over_holds got ack1=%b done=%b result=%b want 0 1 10", ack1, done, result);
      end
    end
    hit1 = 0;
    target = 255;
    start_match();
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_match();
    hit1 = 1;
    @(posedge clk); @(negedge clk);
    total++;
    if (score_w !== 1'b1) begin
      bad++;
      $display("FAIL mid_lock0 got score_w=%b want 1", score_w);
    end
    rst = 1; hit1 = 0;
    @(posedge clk); @(negedge clk);
    total++;
    if (score_w !== 1'b0 || ack1 !== 1'b0 || busy !== 1'b0 || cnt_rst !== 1'b1 || result !== 2'b00) begin
      bad++;
      $display("FAIL mid_reset got score_w=%b ack1=%b busy=%b cnt_rst=%b result=%b want 0 0 0 1 00",
               score_w, ack1, busy, cnt_rst, result);
    end
    rst = 0;
  endtask

  // Reference: arbitration by eligibility time and a tie-break owner, checked every cycle
  task automatic test_random(input int ncyc);
    int  next_ok = 0;
    bit  prio2 = 0;
    bit  e1, e2;
    do_reset();
    start_match();
    for (int edge_i = 0; edge_i < ncyc; edge_i++) begin
      if (ack1) hit1 = 0; else if (!hit1 && $urandom_range(0, 1) == 0) hit1 = 1;
      if (ack2) hit2 = 0; else if (!hit2 && $urandom_range(0, 1) == 0) hit2 = 1;
      @(posedge clk);
      e1 = 0; e2 = 0;
      if (edge_i >= next_ok && (hit1 || hit2)) begin
        if (hit1 && (!hit2 || !prio2)) begin e1 = 1; prio2 = 1; end
        else begin e2 = 1; prio2 = 0; end
        next_ok = edge_i + LOCKOUT + 1;
      end
      @(negedge clk);
      total++;
      if ({ack1, score_w, ack2, score_l, busy, done} !== {e1, e1, e2, e2, 1'b1, 1'b0}) begin
        bad++;
        $display("FAIL random_cycle_%0d got ack1/sw/ack2/sl/busy/done=%b want %b", edge_i,
                 {ack1, score_w, ack2, score_l, busy, done}, {e1, e1, e2, e2, 1'b1, 1'b0});
      end
    end
    hit1 = 0; hit2 = 0;
  endtask

`ifdef MATCH_TIMEOUT_EN
  task automatic test_timeout();
    int n = 1;
    do_reset();
    start_match();
    while (n < 40) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    total++;
    if (n != TIMEOUT || done !== 1'b1 || timeout !== 1'b1 || result !== 2'b00) begin
      bad++;
      $display("FAIL timeout got play_cycles=%0d done=%b timeout=%b result=%b want %0d 1 1 00",
               n, done, timeout, result, TIMEOUT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_point();
    test_simultaneous();
    test_full_match();
    test_reset_mid();
    test_random(400);
`ifdef MATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
